// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TMR_W = 8;

  localparam logic [XLEN-1:0] IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_BUSERR   = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

  // Payload presented to decode alongside the PC.
  typedef struct packed {
    logic [XLEN-1:0] word;
    logic            fault;
    logic [1:0]      cause;
  } fetch_rsp_t;

  function automatic fetch_rsp_t fault_rsp(input logic [1:0] cause);
    fetch_rsp_t r;
    r.word  = '0;
    r.fault = 1'b1;
    r.cause = cause;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_timer.sv
// Saturating 8-bit response timer; expire_o is high while the count equals TIMEOUT_CYCLES-1.
module ifu_timer
  import ifu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] SAT   = '1;

  logic [TMR_W-1:0] count_q, count_d;
  logic             expire_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != SAT)) begin
      count_d = count_q + TMR_W'(1);
    end
  end

  // Expire is registered from the next count so it tracks count_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      expire_q <= (LIMIT == '0);
    end else begin
      count_q  <= count_d;
      expire_q <= (count_d == LIMIT);
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem read, result held for decode,
// with misalign / bus-error / timeout faults and stale-response dropping.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = IFU_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  fetch_rsp_t  rsp_q, rsp_d;
  logic        stale_q, stale_d;

  logic req_valid, req_hs;
  logic tmr_clr, tmr_en, tmr_expire;

  // A stale response must drain before a new request goes out.
  assign req_valid = (state_q == IFU_REQ) && !stale_q;
  assign req_hs    = req_valid && imem_req_ready;
  assign tmr_en    = (state_q == IFU_WAIT);

  ifu_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rsp_d   = rsp_q;
    stale_d = stale_q;
    tmr_clr = 1'b0;

    if (stale_q && imem_resp_valid) begin
      stale_d = 1'b0;
    end

    if (flush) begin
      state_d = IFU_IDLE;
      // A request already in flight will still answer; mark it for dropping.
      if ((state_q == IFU_REQ) && req_hs) begin
        stale_d = 1'b1;
      end
      if ((state_q == IFU_WAIT) && !imem_resp_valid) begin
        stale_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IFU_IDLE: begin
          if (pc_valid) begin
            pc_d = pc_in;
            if (pc_in[1:0] != 2'b00) begin
              rsp_d   = fault_rsp(FC_MISALIGN);
              state_d = IFU_HOLD;
            end else begin
              state_d = IFU_REQ;
            end
          end
        end
        IFU_REQ: begin
          if (req_hs) begin
            tmr_clr = 1'b1;
            state_d = IFU_WAIT;
          end
        end
        IFU_WAIT: begin
          if (imem_resp_valid && !stale_q) begin
            rsp_d.word  = imem_resp_data;
            rsp_d.fault = 1'b0;
            rsp_d.cause = FC_NONE;
            if (imem_resp_err) begin
              rsp_d = fault_rsp(FC_BUSERR);
            end
            state_d = IFU_HOLD;
          end else if (tmr_expire) begin
            rsp_d   = fault_rsp(FC_TIMEOUT);
            stale_d = 1'b1;
            state_d = IFU_HOLD;
          end
        end
        IFU_HOLD: begin
          if (inst_ready) begin
            state_d = IFU_IDLE;
          end
        end
        default: state_d = IFU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IFU_IDLE;
      pc_q    <= RESET_PC;
      rsp_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rsp_q   <= rsp_d;
      stale_q <= stale_d;
    end
  end

  assign pc_ready       = (state_q == IFU_IDLE);
  assign imem_req_valid = req_valid;
  assign imem_addr      = word_align(pc_q);
  assign inst_valid     = (state_q == IFU_HOLD);
  assign inst           = rsp_q.word;
  assign inst_pc        = pc_q;
  assign fault          = rsp_q.fault;
  assign fault_cause    = rsp_q.cause;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: vector table, directed corner sequences and a
// randomized run scored against a transaction-level expectation queue.
module tb_ifu;

  localparam int unsigned TMO   = 255;
  localparam int          NRAND = 60;

  logic        clk, rst;
  logic [31:0] pc_in;
  logic        pc_valid, pc_ready, flush;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid, imem_resp_err;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        fault;
  logic [1:0]  fault_cause;

  ifu #(
    .RESET_PC       (32'h8000_0000),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_valid        (pc_valid),
    .pc_ready        (pc_ready),
    .flush           (flush),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .fault           (fault),
    .fault_cause     (fault_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory image used by the random run: contents and error map by address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (a[5:2] == 4'd9);
  endfunction

  // Aligned fetch with zero-wait memory and decode always ready.
  task automatic zw_fetch(input logic [31:0] pc, input logic [31:0] data, input string tag);
    chk({tag, "_pc_ready"}, 32'(pc_ready), 32'd1);
    pc_in = pc; pc_valid = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    step();
    pc_valid = 1'b0;
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
    chk({tag, "_req_addr"}, imem_addr, pc);
    step();
    imem_resp_valid = 1'b1; imem_resp_data = data; imem_resp_err = 1'b0;
    step();
    imem_resp_valid = 1'b0;
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_inst"}, inst, data);
    chk({tag, "_inst_pc"}, inst_pc, pc);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    step();
    chk({tag, "_consumed"}, 32'(inst_valid), 32'd0);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
    logic [31:0] exp_inst;
    logic        exp_fault;
    logic [1:0]  exp_cause;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        f;
    logic [1:0]  c;
  } exp_t;

  vec_t        vecs[8];
  vec_t        v;
  exp_t        q[$];
  exp_t        e;
  logic [31:0] keep_inst, keep_pc, paddr, pc_gen;
  int          n, pend, dly, consumed;

  initial begin
    vecs[0] = '{32'h8000_0000, 32'h0000_0297, 1'b0, 32'h0000_0297, 1'b0, 2'd0};
    vecs[1] = '{32'h8000_0004, 32'h0010_0093, 1'b0, 32'h0010_0093, 1'b0, 2'd0};
    vecs[2] = '{32'h8000_0002, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b1, 2'd1};
    vecs[3] = '{32'h8000_0008, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 2'd2};
    vecs[4] = '{32'h8000_0003, 32'h2222_2222, 1'b0, 32'h0000_0000, 1'b1, 2'd1};
    vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 2'd0};
    vecs[6] = '{32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0, 2'd0};
    vecs[7] = '{32'h8000_0001, 32'h3333_3333, 1'b0, 32'h0000_0000, 1'b1, 2'd1};

    rst = 1'b1; pc_in = '0; pc_valid = 1'b0; flush = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    imem_resp_err = 1'b0; inst_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_pc_ready", 32'(pc_ready), 32'd1);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'h8000_0000);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);

    // Vector table: one fetch per entry, zero-wait memory, decode ready.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      chk("tbl_pc_ready", 32'(pc_ready), 32'd1);
      pc_in = v.pc; pc_valid = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      step();
      pc_valid = 1'b0;
      if (v.pc[1:0] != 2'b00) begin
        chk("tbl_mis_no_req", 32'(imem_req_valid), 32'd0);
        chk("tbl_mis_valid_c1", 32'(inst_valid), 32'd1);
      end else begin
        chk("tbl_req_valid_c1", 32'(imem_req_valid), 32'd1);
        chk("tbl_req_addr", imem_addr, v.pc & 32'hFFFF_FFFC);
        step();
        chk("tbl_wait_no_valid", 32'(inst_valid), 32'd0);
        imem_resp_valid = 1'b1; imem_resp_data = v.data; imem_resp_err = v.err;
        step();
        imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
        chk("tbl_valid_c3", 32'(inst_valid), 32'd1);
      end
      chk("tbl_inst", inst, v.exp_inst);
      chk("tbl_inst_pc", inst_pc, v.pc);
      chk("tbl_fault", 32'(fault), 32'(v.exp_fault));
      chk("tbl_cause", 32'(fault_cause), 32'(v.exp_cause));
      step();
      chk("tbl_consumed", 32'(inst_valid), 32'd0);
    end

    // Backpressure on the request channel (3 cycles) and on decode (5 cycles).
    pc_in = 32'h8000_0010; pc_valid = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0;
    step();
    pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_held", 32'(imem_req_valid), 32'd1);
      chk("bp_addr_held", imem_addr, 32'h8000_0010);
      step();
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("bp_req_dropped", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFE_F00D;
    step();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(inst_valid), 32'd1);
      chk("bp_hold_inst", inst, 32'hCAFE_F00D);
      chk("bp_hold_pc", inst_pc, 32'h8000_0010);
      step();
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("bp_single_consume", 32'(inst_valid), 32'd0);
    step();
    chk("bp_stays_idle", 32'(pc_ready), 32'd1);

    // Timeout: 255 WAIT cycles without a response.
    pc_in = 32'h8000_0020; pc_valid = 1'b1; imem_req_ready = 1'b1;
    step();
    pc_valid = 1'b0;
    chk("tmo_req", 32'(imem_req_valid), 32'd1);
    step();
    n = 0;
    while (inst_valid !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk("tmo_wait_cycles", 32'(n), 32'(TMO));
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_cause", 32'(fault_cause), 32'd3);
    chk("tmo_inst", inst, 32'd0);
    chk("tmo_inst_pc", inst_pc, 32'h8000_0020);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    // Next fetch must wait for the late response to be dropped.
    pc_in = 32'h8000_0024; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tmo_stale_blocks_req", 32'(imem_req_valid), 32'd0);
      step();
    end
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    chk("tmo_req_after_drop", 32'(imem_req_valid), 32'd1);
    chk("tmo_addr_after_drop", imem_addr, 32'h8000_0024);
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
    step();
    imem_resp_valid = 1'b0;
    chk("tmo_next_valid", 32'(inst_valid), 32'd1);
    chk("tmo_next_inst", inst, 32'h1111_1111);
    chk("tmo_next_fault", 32'(fault), 32'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // Flush in WAIT; the late response must never reach inst.
    pc_in = 32'h8000_0030; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle", 32'(pc_ready), 32'd1);
    chk("flush_no_valid", 32'(inst_valid), 32'd0);
    pc_in = 32'h8000_0034; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    chk("flush_stale_blocks_req", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    chk("flush_req_after_drop", 32'(imem_req_valid), 32'd1);
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_2222;
    step();
    imem_resp_valid = 1'b0;
    chk("flush_next_inst", inst, 32'h2222_2222);
    chk("flush_next_pc", inst_pc, 32'h8000_0034);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // Flush with pc_valid in IDLE: PC must not be accepted.
    pc_in = 32'h8000_0040; pc_valid = 1'b1; flush = 1'b1;
    step();
    pc_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_not_accepted", 32'(pc_ready), 32'd1);
    chk("flush_idle_no_req", 32'(imem_req_valid), 32'd0);
    chk("flush_idle_pc_kept", inst_pc, 32'h8000_0034);

    // Asynchronous reset while waiting for a response.
    pc_in = 32'h8000_0044; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    step();
    keep_inst = inst; keep_pc = inst_pc;
    chk("pre_rst_inst", keep_inst, 32'h2222_2222);
    rst = 1'b1;
    #1;
    chk("arst_pc_ready", 32'(pc_ready), 32'd1);
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("arst_inst_valid", 32'(inst_valid), 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_inst_pc", inst_pc, 32'h8000_0000);
    chk("arst_fault", 32'({fault, fault_cause}), 32'd0);
    step();
    rst = 1'b0;
    step();
    zw_fetch(32'h8000_0048, 32'h3333_3333, "post_rst");

    // Randomized run against an expectation queue built from the memory image.
    pend = 0; dly = 0; consumed = 0; paddr = '0;
    for (int cyc = 0; cyc < 6000 && consumed < NRAND; cyc++) begin
      imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
      if (pend != 0) begin
        if (dly == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = data_of(paddr);
          imem_resp_err   = err_of(paddr);
          pend = 0;
        end else begin
          dly--;
        end
      end
      inst_ready = ($urandom_range(0, 2) != 0);
      if (inst_valid && inst_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_inst", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("rnd_inst", inst, e.word);
          chk("rnd_inst_pc", inst_pc, e.pc);
          chk("rnd_fault", 32'(fault), 32'(e.f));
          chk("rnd_cause", 32'(fault_cause), 32'(e.c));
        end
        consumed++;
      end
      imem_req_ready = ($urandom_range(0, 2) != 0);
      if (imem_req_valid && imem_req_ready) begin
        chk("rnd_one_outstanding", 32'(pend), 32'd0);
        if (q.size() == 0) begin
          chk("rnd_req_without_fetch", 32'(q.size()), 32'd1);
        end else begin
          chk("rnd_addr", imem_addr, q[q.size()-1].pc & 32'hFFFF_FFFC);
        end
        pend  = 1;
        dly   = int'($urandom_range(0, 4));
        paddr = imem_addr;
      end
      pc_gen = 32'h8000_0000 + 32'($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 7) == 0) pc_gen = pc_gen + 32'($urandom_range(1, 3));
      pc_in    = pc_gen;
      pc_valid = ($urandom_range(0, 1) == 1);
      if (pc_valid && pc_ready) begin
        if (pc_gen[1:0] != 2'b00)  q.push_back('{pc_gen, 32'd0, 1'b1, 2'd1});
        else if (err_of(pc_gen))   q.push_back('{pc_gen, 32'd0, 1'b1, 2'd2});
        else                       q.push_back('{pc_gen, data_of(pc_gen), 1'b0, 2'd0});
      end
      step();
    end
    pc_valid = 1'b0; inst_ready = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    chk("rnd_all_consumed", 32'(consumed), 32'(NRAND));
    chk("rnd_queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
